// File: rtl/store16_imm_sequencer.sv
// Microcode sequencer for store-register-to-immediate-address opcodes (LD (a16),SP / LD (a16),A / LDH (a8),A).
// Walks operand fetch, data write and opcode fetch M-cycles with a one-hot T-step ring and memory wait stall.
module store16_imm_sequencer #(
  parameter int STEPS      = 4,
  parameter int DATA_BYTES = 2,
  parameter int ADDR_MODE  = 0,
  parameter int BYTE_SEL_1 = 1,
  parameter int SRC_SEL    = 4,
  parameter int PC_SEL     = 5,
  parameter int WZ_SEL     = 0,
  parameter int Z_SEL      = 0,
  parameter int W_SEL      = 1
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Start,
  input  logic       i_Mem_Wait,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_IR_Fetch,
  output logic [7:0] o_Write8,
  output logic [5:0] o_Read16,
  output logic [5:0] o_Write16,
  output logic       o_Bus_In,
  output logic       o_Bus_Out,
  output logic       o_Address_Out,
  output logic [1:0] o_Increment16,
  output logic [1:0] o_Bus16_Byte_To_Bus,
  output logic       o_High_Page
);

  typedef enum logic [2:0] {IDLE, IMM_LO, IMM_HI, WR_LO, WR_HI, FETCH} state_t;

  localparam logic [2:0] SRC_IDX = SRC_SEL[2:0];
  localparam logic [2:0] PC_IDX  = PC_SEL[2:0];
  localparam logic [2:0] WZ_IDX  = WZ_SEL[2:0];
  localparam logic [2:0] Z_IDX   = Z_SEL[2:0];
  localparam logic [2:0] W_IDX   = W_SEL[2:0];
  // A single stored byte may come from either half of the source register pair.
  localparam logic [1:0] LO_BYTE = (DATA_BYTES == 1 && BYTE_SEL_1 == 1) ? 2'b10 : 2'b01;

  state_t             state_reg;
  state_t             state_next;
  logic [STEPS-1:0]   step_reg;
  logic               last_step;
  logic               bus_state;
  logic               stall;

  assign last_step = step_reg[STEPS-1];
  assign bus_state = (state_reg == IMM_LO) || (state_reg == IMM_HI) ||
                     (state_reg == WR_LO)  || (state_reg == WR_HI);
  assign stall     = bus_state && last_step && i_Mem_Wait;

  // Successor taken when the current M-cycle completes.
  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:    state_next = i_Start ? IMM_LO : IDLE;
      IMM_LO:  state_next = (ADDR_MODE == 1) ? WR_LO : IMM_HI;
      IMM_HI:  state_next = WR_LO;
      WR_LO:   state_next = (DATA_BYTES == 2) ? WR_HI : FETCH;
      WR_HI:   state_next = FETCH;
      FETCH:   state_next = i_Start ? IMM_LO : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_reg <= IDLE;
      step_reg  <= STEPS'(1);
    end else if (state_reg == IDLE) begin
      state_reg <= state_next;
      step_reg  <= STEPS'(1);
    end else if (last_step) begin
      if (!stall) begin
        state_reg <= state_next;
        step_reg  <= STEPS'(1);
      end
    end else begin
      step_reg <= {step_reg[STEPS-2:0], step_reg[STEPS-1]};
    end
  end

  always_comb begin
    o_Busy              = (state_reg != IDLE);
    o_Done              = 1'b0;
    o_IR_Fetch          = 1'b0;
    o_Write8            = '0;
    o_Read16            = '0;
    o_Write16           = '0;
    o_Bus_In            = 1'b0;
    o_Bus_Out           = 1'b0;
    o_Address_Out       = 1'b0;
    o_Increment16       = 2'b00;
    o_Bus16_Byte_To_Bus = 2'b00;
    o_High_Page         = 1'b0;
    case (state_reg)
      IMM_LO, IMM_HI: begin
        if (step_reg[0]) begin
          o_Read16[PC_IDX] = 1'b1;
          o_Address_Out    = 1'b1;
        end
        if (step_reg[1]) begin
          o_Read16[PC_IDX]  = 1'b1;
          o_Write16[PC_IDX] = 1'b1;
          o_Increment16     = 2'b01;
        end
        if (last_step) begin
          o_Bus_In = 1'b1;
          // Register loads fire only on the clock the memory actually delivers.
          if (!i_Mem_Wait) begin
            if (state_reg == IMM_LO) begin
              o_Write8[Z_IDX] = 1'b1;
              o_High_Page     = (ADDR_MODE == 1);
            end else begin
              o_Write8[W_IDX] = 1'b1;
            end
          end
        end
      end
      WR_LO, WR_HI: begin
        if (step_reg[0]) begin
          o_Read16[WZ_IDX] = 1'b1;
          o_Address_Out    = 1'b1;
        end
        if (step_reg[1] && state_reg == WR_LO && DATA_BYTES == 2) begin
          o_Read16[WZ_IDX]  = 1'b1;
          o_Write16[WZ_IDX] = 1'b1;
          o_Increment16     = 2'b01;
        end
        if (last_step) begin
          o_Read16[SRC_IDX]   = 1'b1;
          o_Bus_Out           = 1'b1;
          o_Bus16_Byte_To_Bus = (state_reg == WR_LO) ? LO_BYTE : 2'b10;
        end
      end
      FETCH: begin
        o_IR_Fetch = 1'b1;
        o_Done     = last_step;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_store16_imm_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed control-word events, per-DUT monitors compare them.
// Instance a uses default parameters; instance b is the LDH (a8),A style single-byte high-page variant.
module tb_store16_imm_sequencer;

  typedef struct packed {
    int         cyc;
    logic       busy;
    logic       done;
    logic       irf;
    logic [7:0] w8;
    logic [5:0] r16;
    logic [5:0] w16;
    logic       bin;
    logic       bout;
    logic       aout;
    logic [1:0] inc;
    logic [1:0] bsel;
    logic       hp;
  } obs_t;

  localparam logic [5:0] PC   = 6'b100000;
  localparam logic [5:0] WZ   = 6'b000001;
  localparam logic [5:0] SP   = 6'b010000;
  localparam logic [5:0] SRCB = 6'b001000;
  localparam int BIG = 1000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a = 1'b1, start_a = 1'b0, wait_a = 1'b0;
  logic rst_b = 1'b1, start_b = 1'b0, wait_b = 1'b0;

  logic       busy_a, done_a, irf_a, bin_a, bout_a, aout_a, hp_a;
  logic [7:0] w8_a;
  logic [5:0] r16_a, w16_a;
  logic [1:0] inc_a, bsel_a;
  logic       busy_b, done_b, irf_b, bin_b, bout_b, aout_b, hp_b;
  logic [7:0] w8_b;
  logic [5:0] r16_b, w16_b;
  logic [1:0] inc_b, bsel_b;

  store16_imm_sequencer dut_a (
    .i_Clk(clk), .i_Reset(rst_a), .i_Start(start_a), .i_Mem_Wait(wait_a),
    .o_Busy(busy_a), .o_Done(done_a), .o_IR_Fetch(irf_a), .o_Write8(w8_a),
    .o_Read16(r16_a), .o_Write16(w16_a), .o_Bus_In(bin_a), .o_Bus_Out(bout_a),
    .o_Address_Out(aout_a), .o_Increment16(inc_a), .o_Bus16_Byte_To_Bus(bsel_a),
    .o_High_Page(hp_a)
  );

  store16_imm_sequencer #(.DATA_BYTES(1), .ADDR_MODE(1), .SRC_SEL(3), .BYTE_SEL_1(1)) dut_b (
    .i_Clk(clk), .i_Reset(rst_b), .i_Start(start_b), .i_Mem_Wait(wait_b),
    .o_Busy(busy_b), .o_Done(done_b), .o_IR_Fetch(irf_b), .o_Write8(w8_b),
    .o_Read16(r16_b), .o_Write16(w16_b), .o_Bus_In(bin_b), .o_Bus_Out(bout_b),
    .o_Address_Out(aout_b), .o_Increment16(inc_b), .o_Bus16_Byte_To_Bus(bsel_b),
    .o_High_Page(hp_b)
  );

  obs_t exp_a[$];
  obs_t exp_b[$];
  int checks = 0;
  int errors = 0;

  function automatic obs_t base(int c, logic busy);
    obs_t e;
    e = '0;
    e.cyc = c;
    e.busy = busy;
    return e;
  endfunction

  task automatic put_a(obs_t e, int lim);
    if (e.cyc <= lim) exp_a.push_back(e);
  endtask

  // Default LD (a16),SP: d extra wait clocks at the WR_LO last step, events up to cycle lim.
  task automatic push_a(int t, int d, int lim, bit fall);
    obs_t e;
    for (int k = 0; k < 2; k++) begin
      e = base(t + 1 + 4*k, 1); e.r16 = PC; e.aout = 1; put_a(e, lim);
      e = base(t + 2 + 4*k, 1); e.r16 = PC; e.w16 = PC; e.inc = 2'b01; put_a(e, lim);
      e = base(t + 4 + 4*k, 1); e.bin = 1; e.w8 = (k == 0) ? 8'h01 : 8'h02; put_a(e, lim);
    end
    e = base(t + 9, 1);  e.r16 = WZ; e.aout = 1; put_a(e, lim);
    e = base(t + 10, 1); e.r16 = WZ; e.w16 = WZ; e.inc = 2'b01; put_a(e, lim);
    for (int i = 0; i <= d; i++) begin
      e = base(t + 12 + i, 1); e.r16 = SP; e.bout = 1; e.bsel = 2'b01; put_a(e, lim);
    end
    e = base(t + 13 + d, 1); e.r16 = WZ; e.aout = 1; put_a(e, lim);
    e = base(t + 16 + d, 1); e.r16 = SP; e.bout = 1; e.bsel = 2'b10; put_a(e, lim);
    for (int i = 0; i < 4; i++) begin
      e = base(t + 17 + d + i, 1); e.irf = 1; e.done = (i == 3); put_a(e, lim);
    end
    if (fall) put_a(base(t + 21 + d, 0), lim);
  endtask

  // High-page single-byte store of A: d extra wait clocks at the IMM_LO last step.
  task automatic push_b(int t, int d);
    obs_t e;
    e = base(t + 1, 1); e.r16 = PC; e.aout = 1; exp_b.push_back(e);
    e = base(t + 2, 1); e.r16 = PC; e.w16 = PC; e.inc = 2'b01; exp_b.push_back(e);
    for (int i = 0; i < d; i++) begin
      e = base(t + 4 + i, 1); e.bin = 1; exp_b.push_back(e);
    end
    e = base(t + 4 + d, 1); e.bin = 1; e.w8 = 8'h01; e.hp = 1; exp_b.push_back(e);
    e = base(t + 5 + d, 1); e.r16 = WZ; e.aout = 1; exp_b.push_back(e);
    e = base(t + 8 + d, 1); e.r16 = SRCB; e.bout = 1; e.bsel = 2'b10; exp_b.push_back(e);
    for (int i = 0; i < 4; i++) begin
      e = base(t + 9 + d + i, 1); e.irf = 1; e.done = (i == 3); exp_b.push_back(e);
    end
    exp_b.push_back(base(t + 13 + d, 0));
  endtask

  task automatic compare(string name, obs_t o, obs_t e);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h required=%h", name, o.cyc, o, e);
    end else begin
      $display("ok   %s cyc=%0d word=%h", name, o.cyc, o);
    end
  endtask

  logic busy_prev_a = 1'b0, rst_prev_a = 1'b0;
  always @(negedge clk) begin
    obs_t o;
    o = '{cyc: cyc, busy: busy_a, done: done_a, irf: irf_a, w8: w8_a, r16: r16_a, w16: w16_a,
          bin: bin_a, bout: bout_a, aout: aout_a, inc: inc_a, bsel: bsel_a, hp: hp_a};
    if (aout_a || bout_a || bin_a || (w8_a != 0) || done_a || irf_a || hp_a || (inc_a != 0) ||
        (busy_prev_a && !busy_a) || rst_prev_a) begin
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected cyc=%0d got=%h required=none", cyc, o);
      end else begin
        compare("a", o, exp_a.pop_front());
      end
    end
    busy_prev_a = busy_a;
    rst_prev_a  = rst_a;
  end

  logic busy_prev_b = 1'b0, rst_prev_b = 1'b0;
  always @(negedge clk) begin
    obs_t o;
    o = '{cyc: cyc, busy: busy_b, done: done_b, irf: irf_b, w8: w8_b, r16: r16_b, w16: w16_b,
          bin: bin_b, bout: bout_b, aout: aout_b, inc: inc_b, bsel: bsel_b, hp: hp_b};
    if (aout_b || bout_b || bin_b || (w8_b != 0) || done_b || irf_b || hp_b || (inc_b != 0) ||
        (busy_prev_b && !busy_b) || rst_prev_b) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected cyc=%0d got=%h required=none", cyc, o);
      end else begin
        compare("b", o, exp_b.pop_front());
      end
    end
    busy_prev_b = busy_b;
    rst_prev_b  = rst_b;
  end

  task automatic goto(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t;
    // Reset held through cycles 0..2: idle words expected on cycles 2 and 3.
    exp_a.push_back(base(2, 0)); exp_a.push_back(base(3, 0));
    exp_b.push_back(base(2, 0)); exp_b.push_back(base(3, 0));
    goto(3);
    rst_a = 1'b0; rst_b = 1'b0;
    goto(5);

    // Plain 20-clock sequence.
    t = cyc; push_a(t, 0, BIG, 1);
    start_a = 1'b1; goto(t + 1); start_a = 1'b0;
    goto(t + 25);

    // Three wait clocks on the WR_LO data write.
    t = cyc; push_a(t, 3, BIG, 1);
    start_a = 1'b1; goto(t + 1); start_a = 1'b0;
    goto(t + 12); wait_a = 1'b1;
    goto(t + 15); wait_a = 1'b0;
    goto(t + 28);

    // Reset during WR_HI step1, then a full sequence.
    t = cyc; push_a(t, 0, t + 14, 0);
    start_a = 1'b1; goto(t + 1); start_a = 1'b0;
    goto(t + 14); rst_a = 1'b1; exp_a.push_back(base(t + 15, 0));
    goto(t + 15); rst_a = 1'b0;
    goto(t + 18);
    t = cyc; push_a(t, 0, BIG, 1);
    start_a = 1'b1; goto(t + 1); start_a = 1'b0;
    goto(t + 25);

    // Start while busy is ignored; start on the Done clock chains without a gap.
    t = cyc; push_a(t, 0, BIG, 0);
    start_a = 1'b1; goto(t + 1); start_a = 1'b0;
    goto(t + 7); start_a = 1'b1; goto(t + 8); start_a = 1'b0;
    goto(t + 20); start_a = 1'b1; push_a(t + 20, 0, BIG, 1);
    goto(t + 21); start_a = 1'b0;
    goto(t + 46);

    // High-page single-byte variant, plain and with two wait clocks on the operand read.
    t = cyc; push_b(t, 0);
    start_b = 1'b1; goto(t + 1); start_b = 1'b0;
    goto(t + 16);
    t = cyc; push_b(t, 2);
    start_b = 1'b1; goto(t + 1); start_b = 1'b0;
    goto(t + 4); wait_b = 1'b1;
    goto(t + 6); wait_b = 1'b0;
    goto(t + 19);

    checks++;
    if (exp_a.size() != 0) begin
      errors++;
      $display("FAIL a_pending got=%0d events left required=0", exp_a.size());
    end
    checks++;
    if (exp_b.size() != 0) begin
      errors++;
      $display("FAIL b_pending got=%0d events left required=0", exp_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
